ii_tick_generator: RTL and testbench
====================================

// Module: ii_tick_generator
// PURPOSE
//  Downstream consumer of the clock generator: runs on clkfx_out and turns the programmed
//  iteration interval (div_reg) into one-cycle iteration-start ticks for the global controller.
//  Waits for lock, counts iterations against a limit, aborts on loss of lock.
//  Sits between the clock generator and the global controller iteration-variable counters.
// PARAMETERS
//  ITERATION_VARIABLE_WIDTH  16  width of div_reg (iteration interval, in clk_in cycles)
//  ITER_COUNT_WIDTH          32  width of iteration limit and iteration counter
// PORTS
//  clk_in      in   1    clock, driven by clkfx_out of the clock generator
//  reset_n     in   1    asynchronous, active-low reset
//  locked_in   in   1    locked_out of the clock generator (async; synchronised internally)
//  div_reg     in   ITERATION_VARIABLE_WIDTH  iteration interval II; sampled only at start
//  iter_limit  in   ITER_COUNT_WIDTH  number of iterations; 0 = free-running; sampled at start
//  start       in   1    single-cycle request to begin a run
//  stop        in   1    single-cycle request to end a run
//  tick        out  1    one-cycle pulse marking the start of each iteration
//  iter_count  out  ITER_COUNT_WIDTH  ticks issued in current/last run
//  busy        out  1    high in WAIT_LOCK and RUN
//  done        out  1    high in DONE (limit reached); cleared by next start
//  error       out  1    sticky: II=0 at start, or lock lost while busy; cleared by next accepted start
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE; tick=0, iter_count=0, busy=0, done=0, error=0;
//   synchroniser flops=0, interval counter=0, captured II/limit=0.
//  locked_in passes a 2-flop synchroniser -> lock_s (2-cycle latency); only lock_s is used.
//  States: IDLE, WAIT_LOCK, RUN, DONE.
//  IDLE/DONE + start: if div_reg==0 -> error=1, done=0, stay/return IDLE, no tick.
//   Else capture II=div_reg, LIM=iter_limit; iter_count=0, done=0, error=0; go WAIT_LOCK.
//  WAIT_LOCK: wait until lock_s=1, then go RUN. No timeout. stop -> IDLE.
//  RUN: tick=1 in first RUN cycle; then exactly one tick every II cycles
//   (II=1 -> tick every cycle). Interval counter counts 0..II-1, wraps to 0 on tick.
//   iter_count increments in the cycle after each tick (registered, tick-aligned +1 cycle).
//   If LIM!=0 and the tick just issued is the LIM-th: go DONE next cycle, no further tick.
//   LIM=0: runs until stop or lock loss; iter_count wraps modulo 2^ITER_COUNT_WIDTH silently.
//  stop in WAIT_LOCK/RUN: IDLE next cycle; a tick due in the stop cycle is suppressed;
//   iter_count holds its value; done stays 0.
//  Lock loss: lock_s=0 while in RUN -> IDLE next cycle, error=1, no tick that cycle.
//  Simultaneous: start+stop same cycle -> stop wins (start ignored). start while busy ignored.
//   stop in IDLE/DONE ignored. Lock loss and stop same cycle -> error=1.
//  div_reg/iter_limit changes after start have no effect until the next start.
//  Reset mid-run: immediate return to reset values; no partial tick.
//  All outputs registered; tick is glitch-free, high for exactly one clk_in cycle.
// TESTING
//  1 locked_in=1, div_reg=4, iter_limit=3, start -> ticks 4 cycles apart, 3 total;
//    iter_count=3, done=1, busy=0; no 4th tick.
//  2 div_reg=1, iter_limit=0, start, stop after 10 cycles -> tick every cycle; no tick in stop cycle;
//    iter_count holds; done=0.
//  3 locked_in=0, start, raise locked_in 20 cycles later -> busy=1, no tick while waiting;
//    first tick 3 cycles after rise (2 sync + 1 transition).
//  4 div_reg=5, running; drop locked_in -> within 3 cycles state IDLE, error=1, ticks stop;
//    next valid start clears error.
//  5 div_reg=0, start -> error=1, no tick, busy stays 0; start and stop same cycle -> no run.
//  6 reset_n low mid-run (div_reg=3) -> all outputs 0 immediately; after release idle until start.

Source files
------------

// File: rtl/ii_tick_generator.sv
// Iteration-start tick generator: turns the programmed iteration interval into
// one-cycle ticks on the clkfx_out domain, gated by a synchronised lock.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no run active; start (with non-zero interval) arms a run
// WAIT_LOCK | run armed, waiting for synchronised lock before first tick
// RUN       | issuing one tick every II cycles, counting iterations
// DONE      | iteration limit reached; done held until the next start
module ii_tick_generator #(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int ITER_COUNT_WIDTH         = 32
) (
  input  logic                                clk_in,
  input  logic                                reset_n,
  input  logic                                locked_in,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] div_reg,
  input  logic [ITER_COUNT_WIDTH-1:0]         iter_limit,
  input  logic                                start,
  input  logic                                stop,
  output logic                                tick,
  output logic [ITER_COUNT_WIDTH-1:0]         iter_count,
  output logic                                busy,
  output logic                                done,
  output logic                                error
);

  localparam logic [ITERATION_VARIABLE_WIDTH-1:0] II_ONE  = ITERATION_VARIABLE_WIDTH'(1);
  localparam logic [ITER_COUNT_WIDTH-1:0]         CNT_ONE = ITER_COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state_q;
  state_t state_nxt;

  logic lock_meta;
  logic lock_s;

  logic [ITERATION_VARIABLE_WIDTH-1:0] ii_q;
  logic [ITERATION_VARIABLE_WIDTH-1:0] ii_nxt;
  logic [ITERATION_VARIABLE_WIDTH-1:0] cnt_q;
  logic [ITERATION_VARIABLE_WIDTH-1:0] cnt_nxt;
  logic [ITER_COUNT_WIDTH-1:0]         lim_q;
  logic [ITER_COUNT_WIDTH-1:0]         lim_nxt;
  logic [ITER_COUNT_WIDTH-1:0]         count_nxt;
  logic [ITER_COUNT_WIDTH-1:0]         count_inc;

  logic tick_nxt;
  logic busy_nxt;
  logic done_nxt;
  logic error_nxt;

  // locked_in comes from another clock domain
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked_in;
      lock_s    <= lock_meta;
    end
  end

  assign count_inc = iter_count + CNT_ONE;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick       <= 1'b0;
      iter_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      ii_q       <= '0;
      lim_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_nxt;
      tick       <= tick_nxt;
      iter_count <= count_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      ii_q       <= ii_nxt;
      lim_q      <= lim_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    tick_nxt  = 1'b0;
    count_nxt = iter_count;
    done_nxt  = done;
    error_nxt = error;
    ii_nxt    = ii_q;
    lim_nxt   = lim_q;
    cnt_nxt   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start && !stop) begin
          if (div_reg == '0) begin
            error_nxt = 1'b1;
            done_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            ii_nxt    = div_reg;
            lim_nxt   = iter_limit;
            count_nxt = '0;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            error_nxt = 1'b0;
            state_nxt = WAIT_LOCK;
          end
        end
      end

      WAIT_LOCK: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (lock_s) begin
          state_nxt = RUN;
          tick_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end

      RUN: begin
        // a tick already on the output has been issued, so it is always counted
        if (tick) count_nxt = count_inc;

        if (stop || !lock_s) begin
          state_nxt = IDLE;
          if (!lock_s) error_nxt = 1'b1;
        end else if (tick && (lim_q != '0) && (count_inc == lim_q)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (cnt_q == (ii_q - II_ONE)) begin
          tick_nxt = 1'b1;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt_q + II_ONE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt == WAIT_LOCK) || (state_nxt == RUN);
  end

endmodule

// File: tb/tb_ii_tick_generator.sv
// Bench for ii_tick_generator: directed scenarios followed by random traffic,
// every cycle compared against an arithmetic model of the tick schedule.
module tb_ii_tick_generator;

  localparam int IVW = 16;
  localparam int ICW = 32;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic           clk_in = 1'b0;
  logic           reset_n = 1'b1;
  logic           locked_in = 1'b0;
  logic [IVW-1:0] div_reg = '0;
  logic [ICW-1:0] iter_limit = '0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           tick;
  logic [ICW-1:0] iter_count;
  logic           busy;
  logic           done;
  logic           error;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_mode;
  int unsigned m_rc;
  logic [IVW-1:0] m_ii;
  logic [ICW-1:0] m_lim;
  logic [ICW-1:0] m_cnt;
  logic m_tick, m_busy, m_done, m_err;
  logic m_s0, m_s1;

  always #5 clk_in = ~clk_in;

  ii_tick_generator #(
    .ITERATION_VARIABLE_WIDTH(IVW),
    .ITER_COUNT_WIDTH(ICW)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .locked_in (locked_in),
    .div_reg   (div_reg),
    .iter_limit(iter_limit),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .iter_count(iter_count),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_rc   = 0;
    m_ii   = '0;
    m_lim  = '0;
    m_cnt  = '0;
    m_tick = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_s0   = 1'b0;
    m_s1   = 1'b0;
  endtask

  // Outputs visible after one rising edge, given the inputs present at that edge.
  task automatic model_edge();
    logic        lock_used;
    logic [ICW-1:0] issued;
    if (!reset_n) begin
      model_reset();
      return;
    end
    lock_used = m_s1;
    m_s1 = m_s0;
    m_s0 = locked_in;
    case (m_mode)
      M_WAIT: begin
        m_tick = 1'b0;
        if (stop) m_mode = M_IDLE;
        else if (lock_used) begin
          m_mode = M_RUN;
          m_rc   = 0;
          m_tick = 1'b1;
        end
      end
      M_RUN: begin
        issued = m_cnt + (m_tick ? 32'd1 : 32'd0);
        m_cnt  = issued;
        if (stop || !lock_used) begin
          m_mode = M_IDLE;
          if (!lock_used) m_err = 1'b1;
          m_tick = 1'b0;
        end else if (m_tick && m_lim != 0 && issued == m_lim) begin
          m_mode = M_DONE;
          m_done = 1'b1;
          m_tick = 1'b0;
        end else begin
          m_rc++;
          m_tick = ((m_rc % int'(m_ii)) == 0);
        end
      end
      default: begin
        m_tick = 1'b0;
        if (start && !stop) begin
          if (div_reg == 0) begin
            m_err  = 1'b1;
            m_done = 1'b0;
            m_mode = M_IDLE;
          end else begin
            m_ii   = div_reg;
            m_lim  = iter_limit;
            m_cnt  = '0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_mode = M_WAIT;
          end
        end
      end
    endcase
    m_busy = (m_mode == M_WAIT) || (m_mode == M_RUN);
  endtask

  task automatic compare_all();
    check("tick", tick, m_tick);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("error", error, m_err);
    check("iter_count", iter_count, m_cnt);
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  initial begin
    int n;
    int last;

    model_reset();
    #1 reset_n = 1'b0;
    run(3);
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    check("rst_count", iter_count, 0);
    reset_n = 1'b1;
    run(3);

    // 1: II=4, limit 3
    locked_in = 1'b1;
    run(3);
    div_reg = 16'd4;
    iter_limit = 32'd3;
    pulse_start();
    n = 0;
    last = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (tick === 1'b1) begin
        if (last >= 0) check("t1_gap", i - last, 4);
        last = i;
        n++;
      end
    end
    check("t1_ticks", n, 3);
    check("t1_count", iter_count, 3);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);

    // 2: II=1 free-running, stop after 10 cycles
    div_reg = 16'd1;
    iter_limit = 32'd0;
    pulse_start();
    run(10);
    pulse_stop();
    check("t2_stop_tick", tick, 0);
    check("t2_count", iter_count, 10);
    run(3);
    check("t2_hold", iter_count, 10);
    check("t2_done", done, 0);

    // 3: lock arrives late
    locked_in = 1'b0;
    run(3);
    div_reg = 16'd2;
    pulse_start();
    run(20);
    check("t3_busy_wait", busy, 1);
    locked_in = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && tick !== 1'b1; i++) begin
      cycle();
      n++;
    end
    check("t3_latency", n, 3);
    run(5);
    pulse_stop();
    run(2);

    // 4: lock loss while running
    div_reg = 16'd5;
    pulse_start();
    run(12);
    locked_in = 1'b0;
    n = 0;
    for (int i = 0; i < 6 && error !== 1'b1; i++) begin
      cycle();
      n++;
    end
    check("t4_latency", n, 3);
    check("t4_busy", busy, 0);
    run(5);
    locked_in = 1'b1;
    run(3);
    pulse_start();
    check("t4_err_clear", error, 0);
    check("t4_busy_again", busy, 1);
    run(8);
    pulse_stop();

    // 5: zero interval, and start with stop
    div_reg = 16'd0;
    pulse_start();
    check("t5_err", error, 1);
    check("t5_busy", busy, 0);
    run(5);
    div_reg = 16'd3;
    start = 1'b1;
    stop = 1'b1;
    cycle();
    start = 1'b0;
    stop = 1'b0;
    check("t5_startstop_busy", busy, 0);
    check("t5_startstop_err", error, 1);
    run(5);

    // 6: reset mid-run
    pulse_start();
    run(7);
    #2 reset_n = 1'b0;
    #1;
    check("t6_tick", tick, 0);
    check("t6_busy", busy, 0);
    check("t6_count", iter_count, 0);
    check("t6_err", error, 0);
    model_reset();
    run(2);
    reset_n = 1'b1;
    run(6);
    check("t6_idle", busy, 0);

    // random traffic; inputs change freely while running
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) locked_in = ~locked_in;
      div_reg = 16'($urandom_range(0, 5));
      iter_limit = 32'($urandom_range(0, 5));
      cycle();
    end
    start = 1'b0;
    stop = 1'b0;
    run(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
